// File: rtl/slow_mem_responder.sv
// Fixed-latency line memory answering cache fill/write-back requests one at a time.
// mem_ready pulses for one cycle LATENCY+1 cycles after the request is first sampled.
module slow_mem_responder #(
    parameter int LATENCY = 8,
    parameter int IDX_W   = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [127:0]       wdata_q;
    logic [127:0]       rdata_q;
    logic               ready_q;
    logic               perr_q;
    logic               commit_d;
    logic               unused_addr;

    logic [127:0] mem_q [0:(1<<IDX_W)-1];

    // Upper address bits alias onto the same line by design.
    assign unused_addr = ^mem_addr[27:IDX_W];

    assign commit_d = (state_q == BUSY) && (cnt_q == 8'd0) && wr_q && !proc_reset;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (mem_read || mem_write) begin
                        wr_q    <= mem_write;
                        idx_q   <= mem_addr[IDX_W-1:0];
                        wdata_q <= mem_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                        if (mem_read && mem_write) perr_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        if (!wr_q) rdata_q <= mem_q[idx_q];
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line storage has no reset; an aborted request never reaches commit.
    always_ff @(posedge clk) begin
        if (commit_d) mem_q[idx_q] <= wdata_q;
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Directed bench for slow_mem_responder: latency, data return, aliasing,
// protocol-error flag and reset abort, checked with immediate assertions.
module tb_slow_mem_responder;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D_A   = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [127:0] D_5A  = {16{8'h5A}};
    localparam logic [127:0] D_W2  = 128'h0F0F0F0F_11111111_22222222_33333333;
    localparam logic [127:0] D_AL1 = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    localparam logic [127:0] D_AL2 = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
    localparam logic [127:0] D_C   = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] D_D   = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    localparam logic [127:0] D_E   = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;

    slow_mem_responder #(.LATENCY(LAT), .IDX_W(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = data;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 28'h0, '0);
    endtask

    // Waits for the ready pulse, counting edges from the first edge after the
    // request was driven; the first such edge must be the accepting edge.
    task automatic resp(input bit drop, input bit chk_data, input logic [127:0] exp,
                        input string tag);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (drop && i == 1) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                mem_addr  = 28'h0FFFFFF;
                mem_wdata = '1;
            end
            if (mem_ready) begin
                seen = 1'b1;
                n    = i;
            end
        end
        chk({tag, "_latency"}, 128'(n), 128'(LAT + 1));
        if (chk_data) chk({tag, "_rdata"}, mem_rdata, exp);
    endtask

    // The cycle after the pulse (RESP -> IDLE edge) must have mem_ready low.
    task automatic gap(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_width"}, 128'(mem_ready), 128'(0));
    endtask

    task automatic write_line(input logic [27:0] addr, input logic [127:0] data,
                              input string tag);
        req(1'b0, 1'b1, addr, data);
        resp(1'b0, 1'b0, '0, tag);
        idle();
        gap(tag);
    endtask

    task automatic read_line(input logic [27:0] addr, input logic [127:0] exp,
                             input string tag);
        req(1'b1, 1'b0, addr, '0);
        resp(1'b0, 1'b1, exp, tag);
        idle();
        gap(tag);
    endtask

    initial begin
        proc_reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        proc_reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ready", 128'(mem_ready), 128'(0));
            chk("idle_rdata", mem_rdata, '0);
            chk("idle_perr", 128'(proto_err), 128'(0));
        end

        write_line(28'h0000012, D_A, "wr_12");
        read_line(28'h0000012, D_A, "rd_12");

        // Write-back of line 0x20 immediately followed by fill of line 0x10.
        write_line(28'h0000010, D_5A, "wr_10");
        req(1'b0, 1'b1, 28'h0000020, D_W2);
        resp(1'b0, 1'b0, '0, "wb_20");
        req(1'b1, 1'b0, 28'h0000010, '0);
        gap("wb_20");
        resp(1'b0, 1'b1, D_5A, "fill_10");
        idle();
        gap("fill_10");
        read_line(28'h0000020, D_W2, "rd_20");

        write_line(28'h0000001, D_AL1, "wr_001");
        write_line(28'h0000101, D_AL2, "wr_101");
        read_line(28'h0000001, D_AL2, "alias_001");
        write_line(28'h0000002, D_A, "wr_002");
        chk("rdata_hold_after_write", mem_rdata, D_AL2);
        chk("perr_before_both", 128'(proto_err), 128'(0));

        req(1'b1, 1'b1, 28'h0000003, 128'h1);
        resp(1'b0, 1'b0, '0, "both_3");
        chk("perr_set", 128'(proto_err), 128'(1));
        idle();
        gap("both_3");
        read_line(28'h0000003, 128'h1, "rd_3");
        chk("perr_sticky", 128'(proto_err), 128'(1));

        // Request dropped and inputs scrambled right after acceptance.
        req(1'b0, 1'b1, 28'h0000030, D_E);
        resp(1'b1, 1'b0, '0, "drop_30");
        idle();
        gap("drop_30");
        read_line(28'h0000030, D_E, "rd_30");

        write_line(28'h0000007, D_C, "wr_7");
        req(1'b0, 1'b1, 28'h0000007, D_D);
        repeat (3) @(posedge clk);
        #1;
        proc_reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_rdata", mem_rdata, '0);
        chk("rst_perr", 128'(proto_err), 128'(0));
        begin
            int pulses = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (mem_ready) pulses++;
            end
            chk("rst_no_pulse", 128'(pulses), 128'(0));
        end
        read_line(28'h0000007, D_C, "rd_7_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
